// File: rtl/ysyx_22050243_ifu_if.sv
// Fetch-unit bundle: redirect input, instruction-memory request/response, and decode-side output.
// The master side is the IFU; the slave side is memory plus the ID/EX stages.
interface ysyx_22050243_ifu_if #(
  parameter int unsigned XLEN = 64
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data,
           out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst, out_opcode, out_funct3
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data,
           out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst, out_opcode, out_funct3
  );
endinterface

// File: rtl/ysyx_22050243_ifu.sv
// Instruction fetch unit: owns the PC, keeps one imem read in flight at most, and buffers the
// fetched word for the ID stage. Redirects from EX override the PC in any state.
module ysyx_22050243_ifu #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input logic                 clk,
  input logic                 rst,
  ysyx_22050243_ifu_if.master ifu_io
);

  localparam logic [1:0] StReq  = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            kill_q, kill_d;
  logic            req_valid, out_valid, req_fire, out_fire;

  // A redirect masks both handshakes so nothing is issued or delivered on a stale path.
  always_comb begin
    req_valid = (state_q == StReq) && !ifu_io.redirect_valid && !rst;
    out_valid = (state_q == StHold) && !ifu_io.redirect_valid && !rst;
    req_fire  = req_valid && ifu_io.imem_req_ready;
    out_fire  = out_valid && ifu_io.out_ready;

    ifu_io.imem_req_valid = req_valid;
    ifu_io.imem_req_addr  = pc_q;
    ifu_io.out_valid      = out_valid;
    ifu_io.out_pc         = buf_pc_q;
    ifu_io.out_inst       = inst_q;
    ifu_io.out_opcode     = inst_q[6:0];
    ifu_io.out_funct3     = inst_q[14:12];
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf_pc_d = buf_pc_q;
    inst_d   = inst_q;
    kill_d   = kill_q;

    case (state_q)
      StReq: begin
        if (req_fire) state_d = StWait;
      end
      StWait: begin
        if (ifu_io.imem_resp_valid) begin
          if (kill_q || ifu_io.redirect_valid) begin
            kill_d  = 1'b0;
            state_d = StReq;
          end else begin
            inst_d   = ifu_io.imem_resp_data;
            buf_pc_d = pc_q;
            state_d  = StHold;
          end
        end else if (ifu_io.redirect_valid) begin
          // Response for the old PC is still coming; remember to drop it.
          kill_d = 1'b1;
        end
      end
      StHold: begin
        if (ifu_io.redirect_valid) begin
          state_d = StReq;
        end else if (out_fire) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase

    if (ifu_io.redirect_valid) pc_d = ifu_io.redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StReq;
      pc_q     <= RESET_PC;
      buf_pc_q <= '0;
      inst_q   <= '0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      buf_pc_q <= buf_pc_d;
      inst_q   <= inst_d;
      kill_q   <= kill_d;
    end
  end

  resp_only_in_wait_a : assert property (
    @(posedge clk) disable iff (rst) ifu_io.imem_resp_valid |-> (state_q == StWait)
  );

endmodule

// File: tb/tb_ysyx_22050243_ifu.sv
// Directed bench for the fetch unit: a vector table for the straight-line fetch stream and
// hand-written sequences for stalls, redirects, PC wrap and mid-flight reset.
module tb_ysyx_22050243_ifu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_22050243_ifu_if #(.XLEN(64)) bus ();

  ysyx_22050243_ifu #(
    .XLEN     (64),
    .RESET_PC (64'h8000_0000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ifu_io (bus)
  );

  typedef struct {
    logic        rst;
    logic        rdv;
    logic [63:0] rdpc;
    logic        rdy;
    logic        rsv;
    logic [31:0] rsd;
    logic        ordy;
    logic        e_rqv;
    logic [63:0] e_addr;
    logic        e_ov;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
    logic [6:0]  e_op;
    logic [2:0]  e_f3;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(logic r, logic rdv, logic [63:0] rdpc, logic rdy, logic rsv,
                              logic [31:0] rsd, logic ordy, logic e_rqv, logic [63:0] e_addr,
                              logic e_ov, logic [63:0] e_pc, logic [31:0] e_inst,
                              logic [6:0] e_op, logic [2:0] e_f3);
    vec_t v;
    v.rst = r;     v.rdv = rdv;       v.rdpc = rdpc;  v.rdy = rdy;
    v.rsv = rsv;   v.rsd = rsd;       v.ordy = ordy;  v.e_rqv = e_rqv;
    v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc;  v.e_inst = e_inst;
    v.e_op = e_op; v.e_f3 = e_f3;
    return v;
  endfunction

  // PC at addr, request offered, memory ready as given.
  function automatic vec_t v_req(logic [63:0] addr, logic rdy);
    return mk(0, 0, 0, rdy, 0, 0, 0, 1, addr, 0, 0, 0, 0, 0);
  endfunction

  // Waiting for memory; optional response this cycle.
  function automatic vec_t v_wait(logic [63:0] addr, logic rsv, logic [31:0] d);
    return mk(0, 0, 0, 1, rsv, d, 0, 0, addr, 0, 0, 0, 0, 0);
  endfunction

  // Buffer full, presenting the word fetched from addr.
  function automatic vec_t v_hold(logic [63:0] addr, logic ordy, logic [31:0] inst,
                                  logic [6:0] op, logic [2:0] f3);
    return mk(0, 0, 0, 1, 0, 0, ordy, 0, addr, 1, addr, inst, op, f3);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input string tag, input vec_t v);
    rst                 = v.rst;
    bus.redirect_valid  = v.rdv;
    bus.redirect_pc     = v.rdpc;
    bus.imem_req_ready  = v.rdy;
    bus.imem_resp_valid = v.rsv;
    bus.imem_resp_data  = v.rsd;
    bus.out_ready       = v.ordy;
    #1;
    chk({tag, " req_valid"}, 64'(bus.imem_req_valid), 64'(v.e_rqv));
    chk({tag, " req_addr"}, bus.imem_req_addr, v.e_addr);
    chk({tag, " out_valid"}, 64'(bus.out_valid), 64'(v.e_ov));
    if (v.e_ov) begin
      chk({tag, " out_pc"}, bus.out_pc, v.e_pc);
      chk({tag, " out_inst"}, 64'(bus.out_inst), 64'(v.e_inst));
      chk({tag, " out_opcode"}, 64'(bus.out_opcode), 64'(v.e_op));
      chk({tag, " out_funct3"}, 64'(bus.out_funct3), 64'(v.e_f3));
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] B = 64'h8000_0000;
  vec_t tbl[14];

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, B, 0, 0, 0, 0, 0);
    tbl[1]  = v_req(B, 1);
    tbl[2]  = v_wait(B, 1, 32'h0000_0513);
    tbl[3]  = v_hold(B, 1, 32'h0000_0513, 7'h13, 3'd0);
    tbl[4]  = v_req(B + 4, 1);
    tbl[5]  = v_wait(B + 4, 1, 32'h0010_0093);
    tbl[6]  = v_hold(B + 4, 1, 32'h0010_0093, 7'h13, 3'd0);
    tbl[7]  = v_req(B + 8, 1);
    tbl[8]  = v_wait(B + 8, 1, 32'h0020_a023);
    tbl[9]  = v_hold(B + 8, 1, 32'h0020_a023, 7'h23, 3'd2);
    tbl[10] = v_req(B + 12, 1);
    tbl[11] = v_wait(B + 12, 1, 32'h0000_4463);
    tbl[12] = v_hold(B + 12, 1, 32'h0000_4463, 7'h63, 3'd4);
    tbl[13] = v_req(B + 16, 0);

    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.out_ready       = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) step($sformatf("seq[%0d]", i), tbl[i]);

    // Stall in hold: outputs stable, no new request, then accept.
    step("stall req", v_req(B + 16, 1));
    step("stall resp", v_wait(B + 16, 1, 32'h0000_8067));
    for (int i = 0; i < 5; i++)
      step($sformatf("stall[%0d]", i), v_hold(B + 16, 0, 32'h0000_8067, 7'h67, 3'd0));
    step("stall accept", v_hold(B + 16, 1, 32'h0000_8067, 7'h67, 3'd0));
    step("stall next", v_req(B + 20, 0));

    // Redirect while waiting; late response must be dropped.
    step("rdw req", v_req(B + 20, 1));
    step("rdw redirect", mk(0, 1, B + 64'h100, 0, 0, 0, 0, 0, B + 20, 0, 0, 0, 0, 0));
    step("rdw gap", v_wait(B + 64'h100, 0, 0));
    step("rdw stale", v_wait(B + 64'h100, 1, 32'hdead_beef));
    step("rdw refetch", v_req(B + 64'h100, 1));
    step("rdw resp", v_wait(B + 64'h100, 1, 32'h0000_0013));
    step("rdw out", v_hold(B + 64'h100, 1, 32'h0000_0013, 7'h13, 3'd0));

    // Redirect coincident with response, then with a would-be accept.
    step("rdr req", v_req(B + 64'h104, 1));
    step("rdr resp", mk(0, 1, B + 64'h200, 0, 1, 32'h0000_0093, 0,
                        0, B + 64'h104, 0, 0, 0, 0, 0));
    step("rdr refetch", v_req(B + 64'h200, 1));
    step("rdh resp", v_wait(B + 64'h200, 1, 32'h00a0_0093));
    step("rdh redirect", mk(0, 1, B + 64'h300, 1, 0, 0, 1, 0, B + 64'h200, 0, 0, 0, 0, 0));
    step("rdh next", v_req(B + 64'h300, 0));

    // Redirect in request state to the top of the address space, then wrap.
    step("wrap redirect", mk(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 0,
                             0, B + 64'h300, 0, 0, 0, 0, 0));
    step("wrap req", v_req(64'hFFFF_FFFF_FFFF_FFFC, 1));
    step("wrap resp", v_wait(64'hFFFF_FFFF_FFFF_FFFC, 1, 32'h0000_0513));
    step("wrap out", v_hold(64'hFFFF_FFFF_FFFF_FFFC, 1, 32'h0000_0513, 7'h13, 3'd0));
    step("wrap next", v_req(64'h0, 1));

    // Reset while a response is pending.
    step("rst mid", mk(1, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0));
    step("rst req", v_req(B, 1));
    step("rst resp", v_wait(B, 1, 32'h0010_0513));
    step("rst out", v_hold(B, 1, 32'h0010_0513, 7'h13, 3'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
